// File: rtl/irq_instruction_queue.sv
// Multi-channel interrupt-instruction front end: arbitrated requesters feed a DEPTH-entry FIFO.
// Build option IRQ_FIXED_PRIORITY_EN selects lowest-index-wins arbitration instead of round-robin.
module irq_instruction_queue #(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            req_valid,
  input  logic [NUM_CH*WIDTH-1:0]      req_instr,
  output logic [NUM_CH-1:0]            req_ready,
  output logic [WIDTH-1:0]             interrupt_instruction,
  input  logic                         irq_ack,
  output logic                         irq_pending,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int SW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SW1 = SW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [SW-1:0]    grant_idx;
  logic             grant_found;
  logic             space;
  logic             accept;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] grant_word;

`ifdef IRQ_FIXED_PRIORITY_EN
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        grant_found = 1'b1;
        grant_idx   = SW'(k);
      end
    end
  end
`else
  logic [SW-1:0]       rr_ptr;
  logic [2*NUM_CH-1:0] rot_valid;
  logic [SW1-1:0]      sum;

  // Rotate so bit 0 is the highest-priority channel, then map the hit back.
  always_comb begin
    rot_valid   = {req_valid, req_valid} >> rr_ptr;
    grant_found = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!grant_found && rot_valid[k]) begin
        grant_found = 1'b1;
        sum         = {1'b0, rr_ptr} + SW1'(k);
        if (sum >= SW1'(NUM_CH))
          sum = sum - SW1'(NUM_CH);
        grant_idx = sum[SW-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      rr_ptr <= '0;
    else if (accept)
      rr_ptr <= (grant_idx == SW'(NUM_CH - 1)) ? '0 : grant_idx + SW'(1);
  end
`endif

  assign grant_word = req_instr[grant_idx*WIDTH +: WIDTH];
  // A full FIFO still has room when the head is consumed in the same cycle.
  assign space      = (count != CW'(DEPTH)) || irq_ack;
  assign accept     = grant_found && space && !reset;
  assign push       = accept && (grant_word != '0);
  assign pop        = irq_ack && (count != '0);
  assign req_ready  = accept ? (NUM_CH'(1) << grant_idx) : '0;

  assign irq_pending           = (count != '0);
  assign interrupt_instruction = irq_pending ? mem[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= grant_word;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if ((|req_valid) && !space)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_irq_instruction_queue.sv
// Scoreboard bench for irq_instruction_queue: queue-based reference model, directed plus random traffic.
module tb_irq_instruction_queue;
  localparam int NUM_CH = 4;
  localparam int DEPTH  = 8;
  localparam int WIDTH  = 32;
  localparam int CW     = $clog2(DEPTH+1);

  logic                     clock;
  logic                     reset;
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH*WIDTH-1:0]  req_instr;
  logic [NUM_CH-1:0]        req_ready;
  logic [WIDTH-1:0]         interrupt_instruction;
  logic                     irq_ack;
  logic                     irq_pending;
  logic [CW-1:0]            count;
  logic                     overflow;

  irq_instruction_queue #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_instr(req_instr),
    .req_ready(req_ready), .interrupt_instruction(interrupt_instruction),
    .irq_ack(irq_ack), .irq_pending(irq_pending), .count(count), .overflow(overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  logic [WIDTH-1:0] exp_q[$];   // words the processor should see, in order
  logic [WIDTH-1:0] mq[$];      // model FIFO contents
  int               rr  = 0;
  bit               ovf = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [NUM_CH*WIDTH-1:0] pack4(input logic [WIDTH-1:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  // One cycle: drive inputs, check registered state against the model, then advance the model.
  task automatic step(input logic [NUM_CH-1:0] v, input logic [NUM_CH*WIDTH-1:0] ins,
                      input logic ack, input logic rst);
    int g;
    int c;
    int base;
    bit sp;
    logic [NUM_CH-1:0] er;
    logic [WIDTH-1:0]  w;
    @(negedge clock);
    req_valid = v;
    req_instr = ins;
    irq_ack   = ack;
    reset     = rst;
    #1;
    chk("count", 64'(count), 64'(mq.size()));
    chk("irq_pending", 64'(irq_pending), 64'(mq.size() != 0));
    chk("overflow", 64'(overflow), 64'(ovf));
    if (mq.size() == 0) chk("nop_when_empty", 64'(interrupt_instruction), 64'h0);
    if (rst) begin
      chk("req_ready_in_reset", 64'(req_ready), 64'h0);
      mq.delete();
      exp_q.delete();
      rr  = 0;
      ovf = 1'b0;
    end else begin
      sp = (mq.size() < DEPTH) || ack;
`ifdef IRQ_FIXED_PRIORITY_EN
      base = 0;
`else
      base = rr;
`endif
      g = -1;
      for (int k = 0; k < NUM_CH; k++) begin
        c = (base + k) % NUM_CH;
        if (g < 0 && v[c]) g = c;
      end
      er = (g >= 0 && sp) ? (NUM_CH'(1) << g) : '0;
      chk("req_ready", 64'(req_ready), 64'(er));
      if (ack && mq.size() > 0) void'(mq.pop_front());
      if (er != '0) begin
        w = ins[g*WIDTH +: WIDTH];
        if (w != '0) begin
          mq.push_back(w);
          exp_q.push_back(w);
        end
        rr = (g + 1) % NUM_CH;
      end
      if ((|v) && !sp) ovf = 1'b1;
    end
  endtask

  // Monitor: whenever the processor takes the head, it must be the oldest expected word.
  initial begin
    forever begin
      @(negedge clock);
      #3;
      if (!reset && irq_ack && irq_pending) begin
        if (exp_q.size() == 0) chk("head_word_unexpected", 64'(interrupt_instruction), 64'h0);
        else chk("head_word", 64'(interrupt_instruction), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [NUM_CH*WIDTH-1:0] ins;
    logic [NUM_CH-1:0]       v;
    int                      ack_pct;
    reset     = 1'b1;
    req_valid = '0;
    req_instr = '0;
    irq_ack   = 1'b0;
    step('0, '0, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b1);

    // single push then ack
    step(4'b0010, pack4(32'h0, 32'h0040_0001, 32'h0, 32'h0), 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    chk("single_push_head", 64'(interrupt_instruction), 64'h0040_0001);
    step('0, '0, 1'b1, 1'b0);
    step('0, '0, 1'b0, 1'b0);

    // all channels valid, fill to full, overflow, then simultaneous pop/push
    repeat (8) step(4'hF, pack4(32'hA0, 32'hA1, 32'hA2, 32'hA3), 1'b0, 1'b0);
    repeat (2) step(4'b0100, pack4(32'hA0, 32'hA1, 32'hA2, 32'hA3), 1'b0, 1'b0);
    step(4'b0100, pack4(32'hA0, 32'hA1, 32'hB2, 32'hA3), 1'b1, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    repeat (9) step('0, '0, 1'b1, 1'b0);

    // zero word and stray ack
    step(4'b0001, '0, 1'b0, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    step('0, '0, 1'b0, 1'b0);

    // pointer wrap with push/ack pairs
    for (int i = 0; i < 20; i++) begin
      ins = '0;
      ins[(i % NUM_CH)*WIDTH +: WIDTH] = 32'h100 + 32'(i);
      step(NUM_CH'(1) << (i % NUM_CH), ins, 1'b0, 1'b0);
      step('0, '0, 1'b1, 1'b0);
    end

    // reset mid-fill, with overflow set beforehand
    repeat (10) step(4'b1000, pack4(32'h0, 32'h0, 32'h0, 32'hC3), 1'b0, 1'b0);
    repeat (3) step('0, '0, 1'b1, 1'b0);
    step(4'b1000, pack4(32'h0, 32'h0, 32'h0, 32'hC3), 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ack_pct = ((i / 200) % 2 == 0) ? 25 : 75;
      v = NUM_CH'($urandom);
      for (int c = 0; c < NUM_CH; c++)
        ins[c*WIDTH +: WIDTH] = ($urandom_range(7) == 0) ? 32'h0 : $urandom;
      step(v, ins, ($urandom_range(99) < ack_pct), ($urandom_range(399) == 0));
    end

    repeat (DEPTH + 2) step('0, '0, 1'b1, 1'b0);
    step('0, '0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/irq_instruction_queue.md
# irq_instruction_queue

Parametrised interrupt-instruction front end for the CPU top level. Collects instruction words from `NUM_CH` independent requesters (keyboard, timer, display, game logic), arbitrates one per cycle into a `DEPTH`-entry FIFO, and presents the FIFO head on `interrupt_instruction` to the processor. It replaces the single, unbuffered `interrupt_instruction` input with buffered, multi-source, acknowledged delivery.

## Interface
Parameters:
- `NUM_CH`, 4: number of requester channels, 1 to 16.
- `DEPTH`, 8: FIFO entries, power of two, 2 or more.
- `WIDTH`, 32: instruction word width.

Ports:
- `clock`  in  1  single system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_CH  per-channel request valid.
- `req_instr`  in  NUM_CH*WIDTH  channel i's word in bits [i*WIDTH +: WIDTH].
- `req_ready`  out  NUM_CH  one-hot (or zero) grant; the transfer happens when `req_valid[i] & req_ready[i]`.
- `interrupt_instruction`  out  WIDTH  FIFO head word; all zeros (nop) when the FIFO is empty.
- `irq_ack`  in  1  processor consumed the head word this cycle.
- `irq_pending`  out  1  FIFO is non-empty.
- `count`  out  $clog2(DEPTH+1)  current occupancy.
- `overflow`  out  1  sticky flag: a valid request was refused while the FIFO was full.

## Operation
- Storage: `DEPTH`×`WIDTH` register array, with read pointer, write pointer and count. Pointers are $clog2(DEPTH) bits and wrap modulo `DEPTH`.
- `interrupt_instruction` = `mem[rd_ptr]` when `count` != 0, otherwise 0. The output is combinational from registers and has no extra register stage.
- Space available this cycle: `count < DEPTH`, or `count == DEPTH` with `irq_ack` asserted, which allows a simultaneous pop and push when full.
- Arbitration uses round-robin. `rr_ptr` (initially 0) names the highest-priority channel. The first channel with `req_valid` set at or after `rr_ptr`, wrapping around, is granted. `req_ready` is asserted only for that channel and only when space is available.
- After an accepted transfer from channel g, `rr_ptr` becomes (g+1) mod `NUM_CH`. With no transfer, `rr_ptr` holds.
- Zero words: a granted request with `req_instr` of 0 is handshaken (ready high) but discarded. Nothing is enqueued, `count` is unchanged, and `rr_ptr` still advances.
- Pop: `irq_ack` with `count` != 0 advances `rd_ptr` and decrements `count`. `irq_ack` with `count` == 0 is ignored.
- Push and pop in the same cycle leave `count` unchanged and advance both pointers.
- `overflow` is set when any `req_valid` is high, no space is available, and no grant occurs. It is cleared only by `reset`.
- `reset`: pointers, `count`, `rr_ptr` and `overflow` go to 0. Array contents are don't-care. Outputs become: `interrupt_instruction`=0, `irq_pending`=0, `count`=0, `overflow`=0, `req_ready`=0.
- Reset mid-transfer: a handshake coinciding with `reset` is dropped, and reset wins.

## Timing
- Push latency: a word accepted at edge N appears on `interrupt_instruction` after edge N when the FIFO was empty. Otherwise it appears after the pops of all older entries.
- Pop: the head changes on the edge where `irq_ack` is sampled high.
- `req_ready` is combinational from `req_valid`, `irq_ack` and registered state.
- Throughput is one push and one pop per cycle.

## Configuration
- `IRQ_FIXED_PRIORITY_EN`:
  - Defined: the arbiter grants the lowest-index valid channel, and `rr_ptr` is removed.
  - Undefined (default): round-robin as described above.
  - All other behaviour is identical in both builds.

## Test plan
- Reset, then single push: after reset, ch1 pushes 32'h0040_0001 → one cycle later `interrupt_instruction`=32'h0040_0001, `irq_pending`=1, `count`=1; `irq_ack` → outputs return to 0.
- Round-robin fairness: NUM_CH=4, all channels valid continuously with words 0xA0..0xA3, no ack → grant order ch0, ch1, ch2, ch3, ch0, …; FIFO holds A0, A1, A2, A3, A0, ….
- Full, overflow and simultaneous push/pop: fill 8 entries, keep ch2 valid → `req_ready`=0 and `overflow`=1. Then assert `irq_ack` with ch2 valid → pop and push in the same cycle, `count` stays 8.
- Pointer wrap: 20 push/ack pairs through DEPTH=8 → words emerge in order with no loss; `count` never exceeds 8.
- Zero words and stray ack: ch0 presents 32'h0 → handshaken, `count` stays 0. `irq_ack` while empty → no change. Reset mid-fill (count=5) → next cycle `count`=0 and `overflow`=0.
- Fixed-priority build (`IRQ_FIXED_PRIORITY_EN` defined): ch0 and ch3 both valid for 3 cycles → ch0 granted all 3 cycles, ch3 starved.
